// File: rtl/eqmon_pkg.sv
// Shared types and default parameters for the equivalence response monitor.
// Optional build macro: EQMON_DIFF_CAPTURE_EN (see equiv_response_monitor.sv).
package eqmon_pkg;

  localparam int unsigned DefW     = 446;
  localparam int unsigned DefSigW  = 32;
  localparam logic [31:0] DefPoly  = 32'h04C11DB7;
  localparam logic [31:0] DefSeed  = 32'hFFFFFFFF;

  function automatic int unsigned n_chunks(int unsigned w, int unsigned sw);
    return (w + sw - 1) / sw;
  endfunction

  localparam int unsigned N_CHUNKS = n_chunks(DefW, DefSigW);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } eqmon_state_e;

endpackage

// File: rtl/equiv_response_monitor_if.sv
// Sample/result bundle between the stimulus side (master) and the monitor (slave).
interface equiv_response_monitor_if
  import eqmon_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned SIG_W = DefSigW
);
  logic             start;
  logic             sample_valid;
  logic [W-1:0]     y_ref;
  logic [W-1:0]     y_dut;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       mismatch_cnt;
  logic [7:0]       first_mm_idx;
  logic [SIG_W-1:0] signature;
  logic [W-1:0]     first_diff;

  modport master (
    output start, sample_valid, y_ref, y_dut,
    input  busy, done, pass, mismatch_cnt, first_mm_idx, signature, first_diff
  );

  modport slave (
    input  start, sample_valid, y_ref, y_dut,
    output busy, done, pass, mismatch_cnt, first_mm_idx, signature, first_diff
  );
endinterface

// File: rtl/eqmon_misr.sv
// Folds a W-bit word into SIG_W bits (zero-padded chunks XORed from the LSB)
// and compacts it into a Galois-style MISR.
module eqmon_misr
  import eqmon_pkg::*;
#(
  parameter int unsigned      W     = DefW,
  parameter int unsigned      SIG_W = DefSigW,
  parameter logic [SIG_W-1:0] POLY  = DefPoly,
  parameter logic [SIG_W-1:0] SEED  = DefSeed
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [W-1:0]     data,
  output logic [SIG_W-1:0] sig
);

  localparam int unsigned NChunks = n_chunks(W, SIG_W);

  logic [NChunks*SIG_W-1:0] padded;
  logic [SIG_W-1:0]         fold;
  logic [SIG_W-1:0]         sig_q, sig_d;

  always_comb begin
    padded        = '0;
    padded[W-1:0] = data;
    fold          = '0;
    for (int c = 0; c < NChunks; c++) begin
      fold = fold ^ padded[c*SIG_W +: SIG_W];
    end
  end

  assign sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else if (load) begin
      sig_q <= SEED;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/equiv_response_monitor.sv
// Compares reference vs netlist responses over a fixed window and signs the netlist stream.
// Define EQMON_DIFF_CAPTURE_EN to keep y_ref ^ y_dut of the first mismatch on first_diff.
module equiv_response_monitor
  import eqmon_pkg::*;
#(
  parameter int unsigned      W         = DefW,
  parameter int unsigned      N_SAMPLES = 20,
  parameter int unsigned      SIG_W     = DefSigW,
  parameter logic [SIG_W-1:0] POLY      = DefPoly,
  parameter logic [SIG_W-1:0] SEED      = DefSeed
) (
  input logic                     clk,
  input logic                     rst,
  equiv_response_monitor_if.slave bus
);

  localparam logic [7:0] LastIdx = 8'(N_SAMPLES - 1);

  eqmon_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   mm_cnt_q, mm_cnt_d;
  logic [7:0]   first_idx_q, first_idx_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;

  logic start_acc;
  logic accept;
  logic mismatch;

  // start is only honoured outside RUN; a sample in the start cycle is dropped.
  assign start_acc = bus.start && (state_q != StRun);
  assign accept    = (state_q == StRun) && bus.sample_valid;
  assign mismatch  = (bus.y_ref != bus.y_dut);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mm_cnt_d    = mm_cnt_q;
    first_idx_d = first_idx_q;
    done_d      = done_q;
    pass_d      = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StRun;
          cnt_d       = '0;
          mm_cnt_d    = '0;
          first_idx_d = 8'hFF;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end
      end
      StRun: begin
        if (bus.sample_valid) begin
          if (mismatch) begin
            if (mm_cnt_q != 8'hFF) mm_cnt_d = mm_cnt_q + 8'd1;
            if (mm_cnt_q == 8'd0)  first_idx_d = cnt_q;
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LastIdx) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = (mm_cnt_q == 8'd0) && !mismatch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mm_cnt_q    <= '0;
      first_idx_q <= 8'hFF;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mm_cnt_q    <= mm_cnt_d;
      first_idx_q <= first_idx_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  eqmon_misr #(
    .W     (W),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_acc),
    .en   (accept),
    .data (bus.y_dut),
    .sig  (bus.signature)
  );

`ifdef EQMON_DIFF_CAPTURE_EN
  logic [W-1:0] diff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
    end else if (start_acc) begin
      diff_q <= '0;
    end else if (accept && mismatch && (mm_cnt_q == 8'd0)) begin
      diff_q <= bus.y_ref ^ bus.y_dut;
    end
  end

  assign bus.first_diff = diff_q;
`else
  assign bus.first_diff = '0;
`endif

  assign bus.busy         = (state_q == StRun);
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = mm_cnt_q;
  assign bus.first_mm_idx = first_idx_q;

endmodule

// File: tb/tb_equiv_response_monitor.sv
// Randomized scoreboard bench for equiv_response_monitor against a window-level model.
module tb_equiv_response_monitor;

  localparam int unsigned W    = 446;
  localparam int unsigned N    = 20;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  typedef struct {
    logic         pass;
    logic [7:0]   cnt;
    logic [7:0]   idx;
    logic [31:0]  sig;
    logic [W-1:0] diff;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t         exp_q[$];
  logic [W-1:0] vref[N];
  logic [W-1:0] vdut[N];
  logic         done_prev = 1'b0;

  equiv_response_monitor_if u_if ();
  equiv_response_monitor_if u_if1 ();

  equiv_response_monitor #(.N_SAMPLES(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  equiv_response_monitor #(.N_SAMPLES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [447:0] t;
    for (int k = 0; k < 14; k++) t[k*32 +: 32] = $urandom();
    return t[W-1:0];
  endfunction

  // Every response bit i lands on signature bit i mod 32.
  function automatic logic [31:0] model_fold(input logic [W-1:0] y);
    logic [31:0] f = '0;
    for (int i = 0; i < W; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] sh = s << 1;
    return sh ^ ((s >= 32'h8000_0000) ? POLY : 32'h0) ^ f;
  endfunction

  function automatic exp_t model_window();
    exp_t e;
    int   mm = 0;
    e.idx  = 8'hFF;
    e.diff = '0;
    e.sig  = SEED;
    for (int i = 0; i < N; i++) begin
      if (vref[i] != vdut[i]) begin
        if (mm == 0) begin
          e.idx = 8'(i);
`ifdef EQMON_DIFF_CAPTURE_EN
          e.diff = vref[i] ^ vdut[i];
`endif
        end
        if (mm < 255) mm++;
      end
      e.sig = model_step(e.sig, model_fold(vdut[i]));
    end
    e.cnt  = 8'(mm);
    e.pass = (mm == 0);
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, W'(u_if.busy), W'(1'b0));
    check({tag, "_done"}, W'(u_if.done), W'(1'b0));
    check({tag, "_pass"}, W'(u_if.pass), W'(1'b0));
    check({tag, "_mmcnt"}, W'(u_if.mismatch_cnt), W'(8'd0));
    check({tag, "_idx"}, W'(u_if.first_mm_idx), W'(8'hFF));
    check({tag, "_sig"}, W'(u_if.signature), W'(SEED));
    check({tag, "_diff"}, u_if.first_diff, '0);
  endtask

  // Called at a negedge; returns at the negedge of the first DONE cycle.
  task automatic drive_window(input bit gapped, input bit mid_start, input int abort_at);
    if (abort_at < 0) exp_q.push_back(model_window());
    u_if.start        = 1'b1;
    u_if.sample_valid = 1'b1;
    u_if.y_ref        = rand_word();
    u_if.y_dut        = rand_word();
    @(negedge clk);
    u_if.start = 1'b0;
    check("busy_rise", W'(u_if.busy), W'(1'b1));
    for (int i = 0; i < N; i++) begin
      u_if.sample_valid = 1'b1;
      u_if.y_ref        = vref[i];
      u_if.y_dut        = vdut[i];
      if (mid_start && i == 5) u_if.start = 1'b1;
      @(negedge clk);
      u_if.start = 1'b0;
      if (abort_at == i) break;
      if (gapped && i < N - 1) begin
        u_if.sample_valid = 1'b0;
        u_if.y_ref        = rand_word();
        u_if.y_dut        = rand_word();
        @(negedge clk);
      end
    end
    u_if.sample_valid = 1'b0;
    if (abort_at >= 0) begin
      #2 rst = 1'b1;
      #1 check_reset_values("abort");
      @(negedge clk);
      rst = 1'b0;
    end else begin
      check("done_rise", W'(u_if.done), W'(1'b1));
      check("busy_fall", W'(u_if.busy), W'(1'b0));
    end
  endtask

  // Scoreboard monitor: one expected result per completed window.
  always @(negedge clk) begin
    if (!rst && u_if.done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", W'(1'b1), W'(1'b0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pass", W'(u_if.pass), W'(e.pass));
        check("mismatch_cnt", W'(u_if.mismatch_cnt), W'(e.cnt));
        check("first_mm_idx", W'(u_if.first_mm_idx), W'(e.idx));
        check("signature", W'(u_if.signature), W'(e.sig));
        check("first_diff", u_if.first_diff, e.diff);
      end
    end
    done_prev <= u_if.done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.start = 1'b0;  u_if.sample_valid = 1'b0;  u_if.y_ref = '0;  u_if.y_dut = '0;
    u_if1.start = 1'b0; u_if1.sample_valid = 1'b0; u_if1.y_ref = '0; u_if1.y_dut = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single-sample window on the N_SAMPLES=1 instance, all-zero response.
    u_if1.start = 1'b1;
    @(negedge clk);
    u_if1.start        = 1'b0;
    u_if1.sample_valid = 1'b1;
    @(negedge clk);
    u_if1.sample_valid = 1'b0;
    check("n1_done", W'(u_if1.done), W'(1'b1));
    check("n1_pass", W'(u_if1.pass), W'(1'b1));
    check("n1_signature", W'(u_if1.signature), W'(32'hFB3EE249));

    // Identical streams.
    for (int i = 0; i < N; i++) begin
      vref[i] = rand_word();
      vdut[i] = vref[i];
    end
    drive_window(1'b0, 1'b0, -1);
    @(negedge clk);

    // Gapped valid with a mid-RUN start on the same vectors.
    drive_window(1'b1, 1'b1, -1);
    @(negedge clk);

    // Injected mismatches on bit 445 at samples 3 and 7.
    for (int i = 0; i < N; i++) begin
      vref[i] = rand_word();
      vdut[i] = vref[i];
    end
    vdut[3][445] = ~vdut[3][445];
    vdut[7][445] = ~vdut[7][445];
    drive_window(1'b0, 1'b0, -1);
    @(negedge clk);

    // Random multi-bit differences.
    for (int i = 0; i < N; i++) begin
      vref[i] = rand_word();
      vdut[i] = ($urandom_range(0, 3) == 0) ? rand_word() : vref[i];
    end
    drive_window(1'b0, 1'b0, -1);
    @(negedge clk);

    // Reset after sample 5, then a fresh window.
    drive_window(1'b0, 1'b0, 5);
    for (int i = 0; i < N; i++) begin
      vref[i] = rand_word();
      vdut[i] = vref[i];
    end
    vdut[12] = rand_word();
    drive_window(1'b0, 1'b0, -1);
    @(negedge clk);

    // Back-to-back: second window starts in the first DONE cycle.
    for (int i = 0; i < N; i++) begin
      vref[i] = rand_word();
      vdut[i] = vref[i];
    end
    drive_window(1'b0, 1'b0, -1);
    for (int i = 0; i < N; i++) vdut[i] = rand_word();
    for (int i = 1; i < N; i++) vref[i] = vdut[i];
    vref[0] = ~vdut[0];
    drive_window(1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
